down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide `WIDTH`, default 4, as the counter width in bits (legal range 2..32).
REQ-002 The block SHALL provide `RESET_VALUE`, default all-ones (4'hF), as the value loaded by reset and on wrap.
REQ-003 The block SHALL provide `WRAP_EN`, default 1: 1 = wrap to RESET_VALUE after 0; 0 = saturate at 0.

Ports (name, direction, width, meaning):
REQ-004 `clk`, input, 1: the single clock; all state updates on the rising edge.
REQ-005 `reset`, input, 1: synchronous, active-high reset.
REQ-006 `counter`, output, WIDTH: current count, driven directly from a register.
REQ-007 `zero`, output, 1: high while counter == 0 (combinational decode of the register).
REQ-008 `wrap`, output, 1: registered one-cycle pulse, high in the cycle after counter steps 0 -> RESET_VALUE.
REQ-009 The outputs `zero` and `wrap` SHALL be usable unconnected; the block SHALL have no inputs beyond `clk` and `reset`.

Function
REQ-010 On each rising `clk` edge with `reset` low, `counter` SHALL decrement by exactly 1 (modulo behaviour per REQ-011/012), with latency of one cycle.
REQ-011 With WRAP_EN=1, when counter == 0, the next value SHALL be RESET_VALUE, and `wrap` SHALL be 1 for exactly that next cycle.
REQ-012 With WRAP_EN=0, when counter == 0, counter SHALL hold at 0 and `wrap` SHALL stay 0.
REQ-013 Arithmetic SHALL be unsigned WIDTH-bit; no intermediate value SHALL exceed WIDTH bits in the stored register.
REQ-014 If RESET_VALUE exceeds 2^WIDTH-1, it SHALL be truncated to WIDTH bits (lower bits kept).
REQ-015 Full period with WRAP_EN=1 SHALL be RESET_VALUE+1 cycles (16 cycles at defaults).
REQ-016 `wrap` SHALL be 0 at all times other than the cycle defined in REQ-011.

Reset
REQ-017 While `reset` is high at a rising edge, counter SHALL load RESET_VALUE and `wrap` SHALL load 0, overriding counting.
REQ-018 Reset SHALL take effect only at a clock edge; an asserted reset between edges SHALL not change outputs.
REQ-019 Reset asserted mid-count (any value, including 0) SHALL produce RESET_VALUE on the next edge; no wrap pulse SHALL result.
REQ-020 The first decrement after reset deassertion SHALL occur on the first rising edge where `reset` is sampled low (RESET_VALUE -> RESET_VALUE-1).

Structure
REQ-021 A shared package `down_counter_pkg` SHALL hold the default WIDTH (4) and default RESET_VALUE constants.
REQ-022 One sub-module `down_counter_tc` SHALL implement the terminal-count decode (zero detect, next-value select between decrement/wrap/hold); the top SHALL hold the registers.
REQ-023 The design SHALL contain no latches, no asynchronous logic, and a single clock domain.

Verification
REQ-024 Defaults, clk period 10 ns, reset high for 30 ns -> counter = 15 during reset; after release 14, 13, ... on successive edges.
REQ-025 Defaults, free run from reset -> after counter = 0, next edge gives 15 with `wrap` = 1 for exactly one cycle; period 16 cycles.
REQ-026 Reset asserted for one cycle when counter = 7 -> next value 15, `wrap` = 0, counting resumes 14.
REQ-027 Reset asserted when counter = 0 -> next value 15, `wrap` stays 0.
REQ-028 WRAP_EN=0, WIDTH=4 -> counts 15 down to 0 and holds at 0 indefinitely; `zero` = 1 and `wrap` = 0 thereafter.
REQ-029 WIDTH=8, RESET_VALUE=10 -> period 11 cycles (10..0, then 10); `zero` high exactly when counter = 0.

Source files
------------

// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - shared defaults for the down counter
package down_counter_pkg;

  localparam int          DEFAULT_WIDTH       = 4;
  localparam logic [31:0] DEFAULT_RESET_VALUE = 32'h0000_000F;

endpackage

// File: rtl/down_counter_tc.sv
// rtl/down_counter_tc.sv - terminal-count decode and next-value select
module down_counter_tc #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RELOAD  = '1,
  parameter bit               WRAP_EN = 1'b1
) (
  input  logic [WIDTH-1:0] count,
  output logic             zero,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap_next
);

  always_comb begin
    zero       = (count == '0);
    count_next = count - {{(WIDTH-1){1'b0}}, 1'b1};
    wrap_next  = 1'b0;
    // At terminal count either reload (and flag the wrap) or park at zero.
    if (zero) begin
      count_next = WRAP_EN ? RELOAD : '0;
      wrap_next  = WRAP_EN;
    end
  end

endmodule

// File: rtl/down_counter.sv
// rtl/down_counter.sv - free-running down counter with wrap/saturate option
module down_counter
  import down_counter_pkg::*;
#(
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter logic [31:0] RESET_VALUE = DEFAULT_RESET_VALUE,
  parameter bit          WRAP_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] counter,
  output logic             zero,
  output logic             wrap
);

  // Oversized reset values keep only their low WIDTH bits.
  localparam logic [WIDTH-1:0] RELOAD = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  down_counter_tc #(
    .WIDTH   (WIDTH),
    .RELOAD  (RELOAD),
    .WRAP_EN (WRAP_EN)
  ) u_tc (
    .count      (counter_q),
    .zero       (zero),
    .count_next (count_next),
    .wrap_next  (wrap_next)
  );

  always_comb begin
    counter_d = count_next;
    wrap_d    = wrap_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= RELOAD;
      wrap_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
    end
  end

  assign counter = counter_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - randomized bench for down_counter against a count model
module tb_down_counter;

  logic       clk;
  logic       reset;
  logic [3:0] cnt_def, cnt_sat, cnt_trn;
  logic [7:0] cnt_w8;
  logic       zero_def, zero_sat, zero_w8, zero_trn;
  logic       wrap_def, wrap_sat, wrap_w8, wrap_trn;

  int checks = 0;
  int errors = 0;

  int          cfg_w  [4] = '{4, 4, 8, 4};
  int unsigned cfg_raw[4] = '{15, 15, 10, 26};
  bit          cfg_we [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int unsigned cfg_rv [4];
  int unsigned m_cnt  [4];
  bit          m_wrap [4];

  down_counter u_def (
    .clk(clk), .reset(reset), .counter(cnt_def), .zero(zero_def), .wrap(wrap_def)
  );

  down_counter #(.WRAP_EN(1'b0)) u_sat (
    .clk(clk), .reset(reset), .counter(cnt_sat), .zero(zero_sat), .wrap(wrap_sat)
  );

  down_counter #(.WIDTH(8), .RESET_VALUE(32'd10)) u_w8 (
    .clk(clk), .reset(reset), .counter(cnt_w8), .zero(zero_w8), .wrap(wrap_w8)
  );

  down_counter #(.WIDTH(4), .RESET_VALUE(32'h1A)) u_trn (
    .clk(clk), .reset(reset), .counter(cnt_trn), .zero(zero_trn), .wrap(wrap_trn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge of the spec's behaviour for every configuration.
  task automatic model_edge(input logic rst);
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_cnt[i]  = cfg_rv[i];
        m_wrap[i] = 1'b0;
      end else if (m_cnt[i] == 0) begin
        m_cnt[i]  = cfg_we[i] ? cfg_rv[i] : 0;
        m_wrap[i] = cfg_we[i];
      end else begin
        m_cnt[i]  = m_cnt[i] - 1;
        m_wrap[i] = 1'b0;
      end
    end
  endtask

  task automatic check_one(input int i, input logic [31:0] oc, input logic oz, input logic ow);
    checks++;
    assert (oc === 32'(m_cnt[i])) else begin
      errors++;
      $error("FAIL counter[%0d] observed=%0d expected=%0d", i, oc, m_cnt[i]);
    end
    checks++;
    assert (oz === (m_cnt[i] == 0)) else begin
      errors++;
      $error("FAIL zero[%0d] observed=%b expected=%b", i, oz, (m_cnt[i] == 0));
    end
    checks++;
    assert (ow === m_wrap[i]) else begin
      errors++;
      $error("FAIL wrap[%0d] observed=%b expected=%b", i, ow, m_wrap[i]);
    end
  endtask

  task automatic check_all();
    check_one(0, {28'd0, cnt_def}, zero_def, wrap_def);
    check_one(1, {28'd0, cnt_sat}, zero_sat, wrap_sat);
    check_one(2, {24'd0, cnt_w8},  zero_w8,  wrap_w8);
    check_one(3, {28'd0, cnt_trn}, zero_trn, wrap_trn);
  endtask

  task automatic step(input logic rst);
    @(negedge clk);
    reset = rst;
    @(posedge clk);
    #1;
    model_edge(rst);
    check_all();
  endtask

  initial begin
    int first_def, first_w8, first_trn, sat_wraps, guard;

    for (int i = 0; i < 4; i++) cfg_rv[i] = cfg_raw[i] % (32'd1 << cfg_w[i]);
    reset = 1'b1;

    // Reset held for three edges: every counter sits at its reload value.
    for (int n = 0; n < 3; n++) step(1'b1);

    // Free run from reset: measure edges until the first wrap pulse.
    first_def = -1; first_w8 = -1; first_trn = -1; sat_wraps = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1'b0);
      if (wrap_def && first_def < 0) first_def = n;
      if (wrap_w8  && first_w8  < 0) first_w8  = n;
      if (wrap_trn && first_trn < 0) first_trn = n;
      if (wrap_sat) sat_wraps++;
    end
    checks++;
    assert (first_def === 16) else begin
      errors++; $error("FAIL period_def observed=%0d expected=16", first_def);
    end
    checks++;
    assert (first_w8 === 11) else begin
      errors++; $error("FAIL period_w8 observed=%0d expected=11", first_w8);
    end
    checks++;
    assert (first_trn === 11) else begin
      errors++; $error("FAIL period_trn observed=%0d expected=11", first_trn);
    end
    checks++;
    assert (sat_wraps === 0) else begin
      errors++; $error("FAIL sat_wraps observed=%0d expected=0", sat_wraps);
    end

    // Reset mid-count at 7, then resume.
    guard = 0;
    while (m_cnt[0] != 7 && guard < 40) begin step(1'b0); guard++; end
    checks++;
    assert (guard < 40) else begin
      errors++; $error("FAIL reach7 observed=%0d expected<40", guard);
    end
    step(1'b1);
    step(1'b0);
    step(1'b0);

    // Reset exactly at terminal count must not pulse wrap.
    guard = 0;
    while (m_cnt[0] != 0 && guard < 40) begin step(1'b0); guard++; end
    checks++;
    assert (guard < 40) else begin
      errors++; $error("FAIL reach0 observed=%0d expected<40", guard);
    end
    step(1'b1);
    step(1'b0);

    // Reset raised between edges leaves outputs untouched until the edge.
    step(1'b0);
    reset = 1'b1;
    #2;
    check_all();
    @(posedge clk);
    #1;
    model_edge(1'b1);
    check_all();

    // Randomized run with sporadic reset pulses.
    for (int n = 0; n < 400; n++) step($urandom_range(0, 15) == 0);

    // Long quiet run: saturating counter holds at zero without wrapping.
    for (int n = 0; n < 24; n++) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
